imem_loader: RTL and testbench

- Writer side of the instruction memory.
- Receives a framed byte stream on a valid/ready interface and assembles little-endian 32-bit instruction words.
- Drives the instruction memory write port (wena / waddra / dina) and holds the core in reset until a complete image has been loaded.
- Sits beside the core at top level. Its byte input is fed by a UART RX or a debug bridge.

---
 rtl/riscvboy_pkg.sv | 16 +
 rtl/imem_loader_asm.sv | 50 +++++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscvboy_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, frame magic, word geometry.
package riscvboy_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam logic [7:0]  MAGIC_DEF      = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_asm.sv
// Little-endian word assembler: collects bytes into a word and flags the byte that completes it.
module imem_loader_asm
  import riscvboy_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        byte_en_i,
  input  logic [7:0]                  byte_i,
  output logic                        word_done_c_o,
  output logic [BYTES_PER_WORD*8-1:0] word_c_o
);

  localparam int unsigned    IDX_W    = $clog2(BYTES_PER_WORD);
  localparam int unsigned    LO_W     = (BYTES_PER_WORD - 1) * 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LO_W-1:0]  lo_q, lo_d;

  // The final byte is never stored; it is merged combinationally into the completed word.
  always_comb begin
    idx_d = idx_q;
    lo_d  = lo_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_en_i) begin
      if (idx_q == LAST_IDX) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        lo_d[int'(idx_q)*8 +: 8] = byte_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      lo_q  <= '0;
    end else begin
      idx_q <= idx_d;
      lo_q  <= lo_d;
    end
  end

  assign word_done_c_o = byte_en_i && (idx_q == LAST_IDX);
  assign word_c_o      = {byte_i, lo_q};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses MAGIC/LEN/data frames, writes words, holds the core until done.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CSUM_EN.
module imem_loader
  import riscvboy_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH = 32,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_DEPTH   = 2048,
  parameter logic [7:0]  MAGIC       = MAGIC_DEF
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   i_byte_valid,
  input  logic [7:0]             i_byte_data,
  output logic                   o_byte_ready,
  output logic                   o_instr_wena,
  output logic [ADDR_W-1:0]      o_instr_waddra,
  output logic [INSTR_WIDTH-1:0] o_instr_dina,
  output logic                   o_core_hold,
  output logic                   o_load_done,
  output logic                   o_load_err
);

  loader_state_e           state_q;
  logic                    byte_ready_q;
  logic                    wena_q;
  logic [ADDR_W-1:0]       waddra_q;
  logic [INSTR_WIDTH-1:0]  dina_q;
  logic                    core_hold_q;
  logic                    load_done_q;
  logic                    load_err_q;
  logic [7:0]              len_lo_q;
  logic [15:0]             len_q;
  logic [15:0]             word_cnt_q;
  logic [ADDR_W-1:0]       addr_q;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]              csum_q;
`endif

  logic                        accept_c;
  logic                        data_en_c;
  logic                        magic_c;
  logic [15:0]                 len_c;
  logic                        last_word_c;
  logic                        word_done_c;
  logic [BYTES_PER_WORD*8-1:0] word_c;

  assign accept_c    = i_byte_valid && byte_ready_q;
  assign data_en_c   = accept_c && (state_q == ST_DATA);
  assign magic_c     = accept_c && (state_q == ST_IDLE) && (i_byte_data == MAGIC);
  assign len_c       = {i_byte_data, len_lo_q};
  assign last_word_c = (word_cnt_q == (len_q - 16'd1));

  imem_loader_asm u_asm (
    .clk_i         (clk_sys),
    .rst_i         (rst),
    .clr_i         (magic_c),
    .byte_en_i     (data_en_c),
    .byte_i        (i_byte_data),
    .word_done_c_o (word_done_c),
    .word_c_o      (word_c)
  );

  // Frame FSM; every entry into DONE also drops ready and raises the done pulse.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b1;
      wena_q       <= 1'b0;
      waddra_q     <= '0;
      dina_q       <= '0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
      len_lo_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      addr_q       <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      wena_q      <= 1'b0;
      load_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (magic_c) begin
            state_q     <= ST_LEN_LO;
            core_hold_q <= 1'b1;
            load_err_q  <= 1'b0;
            addr_q      <= '0;
          end
        end
        ST_LEN_LO: begin
          if (accept_c) begin
            len_lo_q <= i_byte_data;
            state_q  <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (accept_c) begin
            len_q      <= len_c;
            word_cnt_q <= '0;
            if (len_c == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q      <= ST_CSUM;
`else
              state_q      <= ST_DONE;
              byte_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
`endif
            end else if (32'(len_c) > MEM_DEPTH) begin
              load_err_q <= 1'b1;
              state_q    <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_done_c) begin
            wena_q     <= 1'b1;
            dina_q     <= INSTR_WIDTH'(word_c);
            waddra_q   <= addr_q;
            addr_q     <= addr_q + ADDR_W'(1);
            word_cnt_q <= word_cnt_q + 16'd1;
            if (last_word_c) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_q      <= ST_CSUM;
`else
              state_q      <= ST_DONE;
              byte_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CSUM_EN
        ST_CSUM: begin
          if (accept_c) begin
            if (i_byte_data == csum_q) begin
              state_q      <= ST_DONE;
              byte_ready_q <= 1'b0;
              load_done_q  <= 1'b1;
            end else begin
              load_err_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
`endif
        ST_DONE: begin
          state_q      <= ST_IDLE;
          byte_ready_q <= 1'b1;
          core_hold_q  <= 1'b0;
        end
        default: begin
          state_q      <= ST_IDLE;
          byte_ready_q <= 1'b1;
        end
      endcase
`ifdef IMEM_LOADER_CSUM_EN
      if (magic_c) begin
        csum_q <= '0;
      end else if (data_en_c) begin
        csum_q <= csum_q ^ i_byte_data;
      end
`endif
    end
  end

  assign o_byte_ready   = byte_ready_q;
  assign o_instr_wena   = wena_q;
  assign o_instr_waddra = waddra_q;
  assign o_instr_dina   = dina_q;
  assign o_core_hold    = core_hold_q;
  assign o_load_done    = load_done_q;
  assign o_load_err     = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames against a frame-parsing model.
`timescale 1ns/1ps
module tb_imem_loader;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];
  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_sys = 1'b0;
  logic        rst = 1'b1;
  logic        i_byte_valid = 1'b0;
  logic [7:0]  i_byte_data = 8'h00;
  logic        o_byte_ready;
  logic        o_instr_wena;
  logic [11:0] o_instr_waddra;
  logic [31:0] o_instr_dina;
  logic        o_core_hold;
  logic        o_load_done;
  logic        o_load_err;

  imem_loader dut (
    .clk_sys        (clk_sys),
    .rst            (rst),
    .i_byte_valid   (i_byte_valid),
    .i_byte_data    (i_byte_data),
    .o_byte_ready   (o_byte_ready),
    .o_instr_wena   (o_instr_wena),
    .o_instr_waddra (o_instr_waddra),
    .o_instr_dina   (o_instr_dina),
    .o_core_hold    (o_core_hold),
    .o_load_done    (o_load_done),
    .o_load_err     (o_load_err)
  );

  always #5 clk_sys = ~clk_sys;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  wr_t  got_q[$];
  wr_t  exp_q[$];
  int   got_cyc[$];
  int   got_done = 0;
  int   exp_done = 0;
  logic exp_err = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: records writes/done pulses and checks per-cycle handshake rules.
  always @(negedge clk_sys) begin
    cyc++;
    if (rst) begin
      prev_done = 1'b0;
    end else begin
      if (o_instr_wena) begin
        got_q.push_back('{addr: o_instr_waddra, data: o_instr_dina});
        got_cyc.push_back(cyc);
      end
      if (o_load_done) got_done++;
      check("ready_vs_done", 32'(o_byte_ready), 32'(!o_load_done));
      if (prev_done) check("hold_fall", 32'(o_core_hold), 32'd0);
      prev_done = o_load_done;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference: scan for MAGIC, read LEN, slice the rest into little-endian words.
  task automatic model(input bq_t f);
    int unsigned i = 0;
    int unsigned len;
    logic [7:0]  x = 8'h00;
    logic [31:0] wd;
    exp_q.delete();
    exp_done = 0;
    while (i < f.size() && f[i] != 8'hA5) i++;
    if (i + 2 >= f.size()) return;
    len = {16'd0, f[i+2], f[i+1]};
    i += 3;
    exp_err = 1'b0;
    if (len > 2048) begin
      exp_err = 1'b1;
      return;
    end
    for (int unsigned w = 0; w < len; w++) begin
      wd = {f[i+3], f[i+2], f[i+1], f[i]};
      x ^= f[i] ^ f[i+1] ^ f[i+2] ^ f[i+3];
      exp_q.push_back('{addr: 12'(w), data: wd});
      i += 4;
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (f[i] != x) begin
      exp_err = 1'b1;
      return;
    end
`endif
    exp_done = 1;
  endtask

  function automatic bq_t build(input bq_t pre, input int unsigned len, input wq_t words, input bit bad);
    bq_t f = pre;
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    f.push_back(8'hA5);
    f.push_back(8'(len));
    f.push_back(8'(len >> 8));
    if (len <= 2048) begin
      foreach (words[k]) begin
        for (int s = 0; s < 4; s++) begin
          b = 8'(words[k] >> (8 * s));
          x ^= b;
          f.push_back(b);
        end
      end
      x = bad ? (x ^ 8'h01) : x;
`ifdef IMEM_LOADER_CSUM_EN
      f.push_back(x);
`endif
    end
    return f;
  endfunction

  function automatic wq_t rand_words(input int unsigned n);
    wq_t w;
    for (int unsigned k = 0; k < n; k++) w.push_back($urandom);
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    i_byte_valid = 1'b1;
    i_byte_data  = b;
    while (!o_byte_ready && guard < 16) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 16) check("ready_timeout", 32'(o_byte_ready), 32'd1);
    @(negedge clk_sys);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rdy"},  32'(o_byte_ready),   32'd1);
    check({tag, "_wena"}, 32'(o_instr_wena),   32'd0);
    check({tag, "_addr"}, 32'(o_instr_waddra), 32'd0);
    check({tag, "_dina"}, o_instr_dina,        32'd0);
    check({tag, "_hold"}, 32'(o_core_hold),    32'd1);
    check({tag, "_done"}, 32'(o_load_done),    32'd0);
    check({tag, "_err"},  32'(o_load_err),     32'd0);
  endtask

  task automatic run_frame(input string tag, input bq_t f, input bit gaps);
    model(f);
    got_q.delete();
    got_cyc.delete();
    got_done = 0;
    foreach (f[k]) begin
      if (gaps && $urandom_range(3) == 0) begin
        i_byte_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk_sys);
      end
      send_byte(f[k]);
    end
    i_byte_valid = 1'b0;
    repeat (6) @(negedge clk_sys);
    check({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      check({tag, "_waddr"}, 32'(got_q[k].addr), 32'(exp_q[k].addr));
      check({tag, "_wdata"}, got_q[k].data, exp_q[k].data);
    end
    check({tag, "_ndone"}, 32'(got_done), 32'(exp_done));
    check({tag, "_err"},   32'(o_load_err), 32'(exp_err));
    check({tag, "_hold"},  32'(o_core_hold), (exp_done != 0) ? 32'd0 : 32'd1);
  endtask

  initial begin
    bq_t none;
    bq_t f;
    wq_t w;
    int unsigned len;

    repeat (3) @(negedge clk_sys);
    check_reset("rst0");
    rst = 1'b0;
    @(negedge clk_sys);

    // Two-word image from the bring-up example.
    w = '{32'h00000013, 32'h00100093};
    f = build(none, 2, w, 1'b0);
    run_frame("t1", f, 1'b1);
    check("t1_a0", (got_q.size() > 0) ? 32'(got_q[0].addr) : 32'hxxxxxxxx, 32'd0);
    check("t1_d0", (got_q.size() > 0) ? got_q[0].data : 32'hxxxxxxxx, 32'h00000013);
    check("t1_a1", (got_q.size() > 1) ? 32'(got_q[1].addr) : 32'hxxxxxxxx, 32'd1);
    check("t1_d1", (got_q.size() > 1) ? got_q[1].data : 32'hxxxxxxxx, 32'h00100093);
    check("t1_done", 32'(got_done), 32'd1);

    // Leading junk, then an empty image.
    f = '{8'h00, 8'hFF};
    w.delete();
    f = build(f, 0, w, 1'b0);
    run_frame("t2", f, 1'b0);
    check("t2_nwr", 32'(got_q.size()), 32'd0);
    check("t2_done", 32'(got_done), 32'd1);

    // Oversized LEN, then recovery with a good frame.
    f = build(none, 2049, w, 1'b0);
    run_frame("t3", f, 1'b0);
    check("t3_err", 32'(o_load_err), 32'd1);
    check("t3_hold", 32'(o_core_hold), 32'd1);
    check("t3_nwr", 32'(got_q.size()), 32'd0);
    f = build(none, 3, rand_words(3), 1'b0);
    run_frame("t3b", f, 1'b1);
    check("t3b_err", 32'(o_load_err), 32'd0);

    // Back-to-back bytes: writes every 4 cycles.
    f = build(none, 4, rand_words(4), 1'b0);
    run_frame("t4", f, 1'b0);
    for (int k = 1; k < got_cyc.size(); k++)
      check("t4_spacing", 32'(got_cyc[k] - got_cyc[k-1]), 32'd4);

    // Reset mid-load, after two bytes of word 1.
    got_q.delete();
    f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (f[k]) send_byte(f[k]);
    i_byte_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk_sys);
    check_reset("t5_rst");
    check("t5_nwr", 32'(got_q.size()), 32'd1);
    check("t5_d0", (got_q.size() > 0) ? got_q[0].data : 32'hxxxxxxxx, 32'h44332211);
    rst = 1'b0;
    @(negedge clk_sys);
    f = build(none, 2, rand_words(2), 1'b0);
    run_frame("t5b", f, 1'b1);

    // Largest legal image.
    f = build(none, 2048, rand_words(2048), 1'b0);
    run_frame("t6", f, 1'b0);
    check("t6_lastaddr", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1].addr) : 32'hxxxxxxxx, 32'd2047);

`ifdef IMEM_LOADER_CSUM_EN
    w = '{32'h44332211};
    f = build(none, 1, w, 1'b0);
    run_frame("c1", f, 1'b0);
    check("c1_done", 32'(got_done), 32'd1);
    f = build(none, 1, w, 1'b1);
    run_frame("c2", f, 1'b0);
    check("c2_err", 32'(o_load_err), 32'd1);
    check("c2_done", 32'(got_done), 32'd0);
    check("c2_d0", (got_q.size() > 0) ? got_q[0].data : 32'hxxxxxxxx, 32'h44332211);
`endif

    // Randomized frames: sizes, junk, gaps, oversize LEN and bad checksums.
    for (int r = 0; r < 40; r++) begin
      bq_t pre;
      logic [7:0] jb;
      repeat ($urandom_range(0, 2)) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h5A;
        pre.push_back(jb);
      end
      if ($urandom_range(9) == 0) len = 2049 + $urandom_range(0, 63000);
      else len = $urandom_range(0, 5);
      f = build(pre, len, rand_words((len <= 2048) ? len : 0), ($urandom_range(3) == 0));
      run_frame("rnd", f, $urandom_range(1));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
